vx_ipdom_sequencer: RTL and testbench

//  Per-warp split/join sequencer driving one IPDOM stack instance in the warp scheduler.
//  - Accepts split/join requests from the execute stage over a valid/ready handshake.
//  - Issues stack push/pop with correct pair/entry encoding and honours stack read settling.
//  - Returns the new thread mask and an optional PC redirect.
//  - Flags stack overflow and underflow.

---
 rtl/vx_ipdom_pkg.sv | 27 ++
 rtl/vx_ipdom_sequencer.sv | 135 +++++++++++++
 tb/tb_vx_ipdom_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_ipdom_pkg.sv
// Shared types and state encoding for the per-warp IPDOM split/join sequencer.
// Stack entries are laid out as {mask, pc}, with the mask in the upper bits.
package vx_ipdom_pkg;

  localparam int IPDOM_NT   = 4;
  localparam int IPDOM_PC_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUSH   = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_POP    = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PUSH   = ST_PUSH,
    READ   = ST_READ,
    POP    = ST_POP,
    SETTLE = ST_SETTLE
  } ipdom_state_e;

  typedef struct packed {
    logic [IPDOM_NT-1:0]   mask;
    logic [IPDOM_PC_W-1:0] pc;
  } ipdom_entry_t;

endpackage

// File: rtl/vx_ipdom_sequencer.sv
// Per-warp split/join sequencer that drives one IPDOM stack instance.
// Every output is registered; the SETTLE state gives the stack a cycle to update its pointers.
module vx_ipdom_sequencer
  import vx_ipdom_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 32,
  localparam int ENTRY_W    = NUM_THREADS + PC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_split,
  input  logic [NUM_THREADS-1:0] req_tmask,
  input  logic [NUM_THREADS-1:0] req_then_mask,
  input  logic [PC_W-1:0]        req_pc_else,
  output logic                   rsp_valid,
  output logic [NUM_THREADS-1:0] rsp_tmask,
  output logic                   rsp_br_valid,
  output logic [PC_W-1:0]        rsp_br_pc,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_pair,
  output logic [ENTRY_W-1:0]     stk_q1,
  output logic [ENTRY_W-1:0]     stk_q2,
  input  logic [ENTRY_W-1:0]     stk_d,
  input  logic                   stk_index,
  input  logic                   stk_empty,
  input  logic                   stk_full,
  output logic                   err_overflow,
  output logic                   err_underflow,
  output logic                   busy
);

  ipdom_state_e state;
  logic         read_empty;

  logic [NUM_THREADS-1:0] then_m;
  logic [NUM_THREADS-1:0] else_m;
  logic                   divergent;

  assign then_m    = req_then_mask & req_tmask;
  assign else_m    = ~req_then_mask & req_tmask;
  assign divergent = (then_m != '0) && (then_m != req_tmask);

  // The split response is decided at the handshake edge, so it is already
  // visible in PUSH. An empty join answers immediately from READ, while a
  // non-empty join answers one cycle later from POP using the stack top seen
  // in READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      read_empty    <= 1'b0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_tmask     <= '0;
      rsp_br_valid  <= 1'b0;
      rsp_br_pc     <= '0;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_pair      <= 1'b0;
      stk_q1        <= '0;
      stk_q2        <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      rsp_br_valid <= 1'b0;
      stk_push     <= 1'b0;
      stk_pop      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_is_split) begin
              state     <= PUSH;
              rsp_valid <= 1'b1;
              if (stk_full) begin
                err_overflow <= 1'b1;
                rsp_tmask    <= req_tmask;
                rsp_br_pc    <= '0;
              end else begin
                stk_push <= 1'b1;
                stk_q1   <= {req_tmask, {PC_W{1'b0}}};
                if (divergent) begin
                  stk_pair  <= 1'b1;
                  stk_q2    <= {else_m, req_pc_else};
                  rsp_tmask <= then_m;
                end else begin
                  stk_pair     <= 1'b0;
                  stk_q2       <= '0;
                  rsp_tmask    <= req_tmask;
                  rsp_br_valid <= (then_m == '0);
                end
                rsp_br_pc <= req_pc_else;
              end
            end else begin
              state      <= READ;
              read_empty <= stk_empty;
              if (stk_empty) begin
                err_underflow <= 1'b1;
                rsp_valid     <= 1'b1;
                rsp_tmask     <= req_tmask;
              end
            end
          end
        end
        PUSH: state <= SETTLE;
        READ: begin
          if (read_empty) begin
            state <= SETTLE;
          end else begin
            state        <= POP;
            stk_pop      <= 1'b1;
            rsp_valid    <= 1'b1;
            rsp_tmask    <= stk_d[ENTRY_W-1 -: NUM_THREADS];
            rsp_br_valid <= ~stk_index;
            rsp_br_pc    <= stk_d[PC_W-1:0];
          end
        end
        POP: state <= SETTLE;
        SETTLE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vx_ipdom_sequencer.sv
// Testbench for vx_ipdom_sequencer: directed scenarios followed by random split/join traffic.
// The stack sibling is modelled locally with a depth of 4.
module tb_vx_ipdom_sequencer;
  import vx_ipdom_pkg::*;

  localparam int NT    = 4;
  localparam int PCW   = 32;
  localparam int EW    = NT + PCW;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_is_split = 1'b0;
  logic [NT-1:0] req_tmask = '0;
  logic [NT-1:0] req_then_mask = '0;
  logic [PCW-1:0] req_pc_else = '0;
  logic          rsp_valid;
  logic [NT-1:0] rsp_tmask;
  logic          rsp_br_valid;
  logic [PCW-1:0] rsp_br_pc;
  logic          stk_push, stk_pop, stk_pair;
  logic [EW-1:0] stk_q1, stk_q2, stk_d;
  logic          stk_index, stk_empty, stk_full;
  logic          err_overflow, err_underflow, busy;

  vx_ipdom_sequencer #(.NUM_THREADS(NT), .PC_W(PCW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_split(req_is_split),
    .req_tmask(req_tmask), .req_then_mask(req_then_mask), .req_pc_else(req_pc_else),
    .rsp_valid(rsp_valid), .rsp_tmask(rsp_tmask), .rsp_br_valid(rsp_br_valid),
    .rsp_br_pc(rsp_br_pc), .stk_push(stk_push), .stk_pop(stk_pop), .stk_pair(stk_pair),
    .stk_q1(stk_q1), .stk_q2(stk_q2), .stk_d(stk_d), .stk_index(stk_index),
    .stk_empty(stk_empty), .stk_full(stk_full),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Stack sibling: a pair entry first yields its else half, then its restore half.
  logic [EW-1:0] m_q1 [DEPTH];
  logic [EW-1:0] m_q2 [DEPTH];
  logic          m_idx [DEPTH];
  int            m_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0;
    end else if (stk_push && m_cnt < DEPTH) begin
      m_q1[m_cnt]  = stk_q1;
      m_q2[m_cnt]  = stk_q2;
      m_idx[m_cnt] = ~stk_pair;
      m_cnt++;
    end else if (stk_pop && m_cnt > 0) begin
      if (!m_idx[m_cnt-1]) m_idx[m_cnt-1] = 1'b1;
      else m_cnt--;
    end
  end

  assign stk_empty = (m_cnt == 0);
  assign stk_full  = (m_cnt == DEPTH);
  assign stk_index = (m_cnt > 0) ? m_idx[m_cnt-1] : 1'b0;
  assign stk_d     = (m_cnt > 0) ? (m_idx[m_cnt-1] ? m_q1[m_cnt-1] : m_q2[m_cnt-1]) : '0;

  // Reference model: a flat LIFO of the join responses still owed, plus a nesting level count.
  typedef struct {
    logic [NT-1:0]  mask;
    logic [PCW-1:0] pc;
    bit             br;
  } exp_join_t;

  exp_join_t ref_q[$];
  int        levels = 0;
  bit        exp_ovf = 0, exp_unf = 0;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input bit is_split, input logic [NT-1:0] t,
                               input logic [NT-1:0] th_in, input logic [PCW-1:0] pc);
    logic [NT-1:0] th, el;
    ipdom_entry_t  e1, e2;
    exp_join_t     ej;
    bit            was_empty;
    int            hs, lat, exp_lat;
    th = th_in & t;
    el = ~th_in & t;
    @(negedge clk);
    checkOutput("ready_before_req", req_ready, 1);
    req_valid     = 1'b1;
    req_is_split  = is_split;
    req_tmask     = t;
    req_then_mask = th_in;
    req_pc_else   = pc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    hs = cyc;
    @(negedge clk);
    if (is_split) begin
      exp_lat = 3;
      checkOutput("split_rsp_valid", rsp_valid, 1);
      checkOutput("split_no_pop", stk_pop, 0);
      if (levels == DEPTH) begin
        exp_ovf = 1;
        checkOutput("ovf_no_push", stk_push, 0);
        checkOutput("ovf_rsp_tmask", rsp_tmask, t);
        checkOutput("ovf_br_valid", rsp_br_valid, 0);
      end else begin
        e1.mask = t;
        e1.pc   = '0;
        checkOutput("split_push", stk_push, 1);
        checkOutput("split_q1", stk_q1, e1);
        if (th != 0 && th != t) begin
          e2.mask = el;
          e2.pc   = pc;
          checkOutput("div_pair", stk_pair, 1);
          checkOutput("div_q2", stk_q2, e2);
          checkOutput("div_rsp_tmask", rsp_tmask, th);
          checkOutput("div_br_valid", rsp_br_valid, 0);
          ref_q.push_back('{mask: t, pc: '0, br: 1'b0});
          ref_q.push_back('{mask: el, pc: pc, br: 1'b1});
        end else begin
          checkOutput("uni_pair", stk_pair, 0);
          checkOutput("uni_q2", stk_q2, 0);
          checkOutput("uni_rsp_tmask", rsp_tmask, t);
          checkOutput("uni_br_valid", rsp_br_valid, (th == 0));
          if (th == 0) checkOutput("uni_br_pc", rsp_br_pc, pc);
          ref_q.push_back('{mask: t, pc: '0, br: 1'b0});
        end
        levels++;
      end
    end else begin
      was_empty = (ref_q.size() == 0);
      if (was_empty) begin
        exp_lat = 3;
        exp_unf = 1;
        checkOutput("unf_rsp_valid", rsp_valid, 1);
        checkOutput("unf_no_pop", stk_pop, 0);
        checkOutput("unf_rsp_tmask", rsp_tmask, t);
        checkOutput("unf_br_valid", rsp_br_valid, 0);
      end else begin
        exp_lat = 4;
        ej = ref_q.pop_back();
        if (!ej.br) levels--;
        checkOutput("join_early_rsp", rsp_valid, 0);
        @(negedge clk);
        checkOutput("join_rsp_valid", rsp_valid, 1);
        checkOutput("join_pop", stk_pop, 1);
        checkOutput("join_no_push", stk_push, 0);
        checkOutput("join_rsp_tmask", rsp_tmask, ej.mask);
        checkOutput("join_br_valid", rsp_br_valid, ej.br);
        if (ej.br) checkOutput("join_br_pc", rsp_br_pc, ej.pc);
      end
    end
    while (!req_ready && (cyc - hs) < 10) @(negedge clk);
    lat = cyc - hs + 1;
    checkOutput("ready_latency", lat, exp_lat);
    checkOutput("err_overflow", err_overflow, exp_ovf);
    checkOutput("err_underflow", err_underflow, exp_unf);
    checkOutput("stack_empty", stk_empty, (ref_q.size() == 0));
  endtask

  initial begin
    #12;
    checkOutput("reset_ready", req_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_push", stk_push, 0);
    checkOutput("reset_errs", {err_overflow, err_underflow}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Divergent split followed by its two joins
    applyStimulus(1, 4'b1111, 4'b0011, 32'h8000_1000);
    applyStimulus(0, 4'b1111, 4'b0000, 32'h0);
    applyStimulus(0, 4'b1111, 4'b0000, 32'h0);

    // Uniform splits, taken and not taken
    applyStimulus(1, 4'b1111, 4'b1111, 32'h0000_2000);
    applyStimulus(0, 4'b1111, 4'b0000, 32'h0);
    applyStimulus(1, 4'b1111, 4'b0000, 32'h0000_3000);
    applyStimulus(0, 4'b1111, 4'b0000, 32'h0);

    // Fill the stack, overflow once, drain it, then underflow
    for (int i = 0; i < 5; i++) applyStimulus(1, 4'b1111, 4'b0101, 32'h100 * (i + 1));
    for (int i = 0; i < 9; i++) applyStimulus(0, 4'b1010, 4'b0000, 32'h0);

    // Asynchronous reset while the sequencer is in POP
    applyStimulus(1, 4'b0111, 4'b0001, 32'h0000_4000);
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_split = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pop_before_reset", stk_pop, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset_pop", stk_pop, 0);
    checkOutput("areset_busy", busy, 0);
    checkOutput("areset_errs", {err_overflow, err_underflow}, 0);
    checkOutput("areset_rsp_valid", rsp_valid, 0);
    ref_q.delete();
    levels  = 0;
    exp_ovf = 0;
    exp_unf = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_ready", req_ready, 1);
    checkOutput("post_reset_busy", busy, 0);

    // Random traffic against the reference model
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                    4'($urandom), $urandom & 32'hFFFF_FFFC);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
